// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: constants shared by the datapath ALU blocks.
// Holds the add/sub opcode encoding, default adder geometry and the flag bit order.
package alu_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_BLOCK_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int NUM_FLAGS = 3;

  typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// cla_slice: combinational BLOCK_W-bit carry-lookahead slice.
// Provides the sum, the carry out, group propagate/generate and the carry into its MSB.
module cla_slice #(
  parameter int BLOCK_W = 16
) (
  input  logic [BLOCK_W-1:0] a_i,
  input  logic [BLOCK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [BLOCK_W-1:0] sum_o,
  output logic               cout_o,
  output logic               pg_o,
  output logic               gg_o,
  output logic               c_msb_o
);

  logic [BLOCK_W-1:0] g;
  logic [BLOCK_W-1:0] p;
  logic [BLOCK_W-1:0] c;
  logic               gg_acc;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each bit's carry is a flat generate/propagate term over all lower bits.
  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int k = 0; k < BLOCK_W - 1; k++) begin
      logic grp_g;
      logic grp_p;
      grp_g = g[k];
      grp_p = p[k];
      for (int j = k - 1; j >= 0; j--) begin
        grp_g = grp_g | (grp_p & g[j]);
        grp_p = grp_p & p[j];
      end
      c[k+1] = grp_g | (grp_p & cin_i);
    end
  end

  always_comb begin
    gg_acc = 1'b0;
    for (int j = 0; j < BLOCK_W; j++) begin
      gg_acc = g[j] | (p[j] & gg_acc);
    end
  end

  assign gg_o    = gg_acc;
  assign pg_o    = &p;
  assign cout_o  = gg_acc | (&p & cin_i);
  assign c_msb_o = c[BLOCK_W-1];
  assign sum_o   = p ^ c;

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// pipelined_cla_adder: WIDTH/BLOCK_W-stage pipelined CLA add/sub with valid/ready and C/V/Z flags.
// Define ADDER_SATURATE_EN to add a 'sat' input that clamps signed overflow.
module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int BLOCK_W = DEFAULT_BLOCK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef ADDER_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / BLOCK_W;

  logic [STAGES:0]   adv;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] up_c;
  logic [STAGES-1:0] up_z;
  logic [STAGES-1:0] up_sat;
  logic [WIDTH-1:0]  up_a [STAGES];
  logic [WIDTH-1:0]  up_b [STAGES];

  assign adv[STAGES] = out_ready;
  assign in_ready    = adv[0];

  assign up_valid[0] = in_valid;
  assign up_a[0]     = a;
  assign up_b[0]     = (sub == OP_SUB) ? ~b : b;
  assign up_c[0]     = (sub == OP_SUB) ? 1'b1 : cin;
  assign up_z[0]     = 1'b1;
`ifdef ADDER_SATURATE_EN
  assign up_sat[0]   = sat;
`else
  assign up_sat[0]   = 1'b0;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [BLOCK_W-1:0] s_sum;
    logic               s_cout;
    logic               s_pg;
    logic               s_gg;
    logic               s_cmsb;
    logic               c_d;
    logic               z_d;
    logic [WIDTH-1:0]   a_d;
    logic               valid_q;

    cla_slice #(
      .BLOCK_W (BLOCK_W)
    ) u_slice (
      .a_i     (up_a[i][BLOCK_W-1:0]),
      .b_i     (up_b[i][BLOCK_W-1:0]),
      .cin_i   (up_c[i]),
      .sum_o   (s_sum),
      .cout_o  (s_cout),
      .pg_o    (s_pg),
      .gg_o    (s_gg),
      .c_msb_o (s_cmsb)
    );

    assign c_d = s_gg | (s_pg & up_c[i]);
    assign z_d = up_z[i] & (s_sum == '0);
    // Operand slices shift down while result slices enter at the top, so the
    // word leaving the last stage is the complete sum in its natural position.
    assign a_d = (up_a[i] >> BLOCK_W) | (WIDTH'(s_sum) << (WIDTH - BLOCK_W));

    assign adv[i] = !valid_q || adv[i+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else if (adv[i]) begin
        valid_q <= up_valid[i];
      end
    end

    if (i < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             c_q;
      logic             z_q;
      logic             sat_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
          z_q   <= 1'b0;
          sat_q <= 1'b0;
        end else if (adv[i] && up_valid[i]) begin
          a_q   <= a_d;
          b_q   <= up_b[i] >> BLOCK_W;
          c_q   <= c_d;
          z_q   <= z_d;
          sat_q <= up_sat[i];
        end
      end

      assign up_valid[i+1] = valid_q;
      assign up_a[i+1]     = a_q;
      assign up_b[i+1]     = b_q;
      assign up_c[i+1]     = c_q;
      assign up_z[i+1]     = z_q;
      assign up_sat[i+1]   = sat_q;
    end else begin : g_last
      logic             ovf_w;
      logic             clamp;
      logic [WIDTH-1:0] sat_lim;
      logic [WIDTH-1:0] sum_d;
      logic [WIDTH-1:0] sum_q;
      flags_t           flags_d;
      flags_t           flags_q;

      assign ovf_w = s_cmsb ^ s_cout;
      assign clamp = up_sat[i] & ovf_w;
      // A set wrapped MSB after overflow means the true result was positive.
      assign sat_lim = a_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      assign sum_d   = clamp ? sat_lim : a_d;

      always_comb begin
        flags_d         = '0;
        flags_d[FLAG_C] = c_d;
        flags_d[FLAG_V] = ovf_w;
        flags_d[FLAG_Z] = clamp ? 1'b0 : z_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q   <= '0;
          flags_q <= '0;
        end else if (adv[i] && up_valid[i]) begin
          sum_q   <= sum_d;
          flags_q <= flags_d;
        end
      end

      assign out_valid = valid_q;
      assign sum       = sum_q;
      assign cout      = flags_q[FLAG_C];
      assign ovf       = flags_q[FLAG_V];
      assign zero      = flags_q[FLAG_Z];
    end
  end

endmodule
`default_nettype wire
